// File: rtl/arb_pkg.sv
// Shared types, constants and the round-robin pick function for the
// four-requester arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N = 4;

  // First set bit of mask, scanning ptr, ptr+1, ptr+2, ptr+3 with mod-4 wrap.
  function automatic logic [1:0] pick(input logic [1:0] ptr, input logic [ARB_N-1:0] mask);
    logic [1:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < ARB_N; k++) begin
      idx = ptr + k[1:0];
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

endpackage

// File: rtl/grant_dec.sv
// 2-to-4 decoder with enable: turns the registered (gnt_valid, gnt_id)
// pair into the one-hot grant vector.
module grant_dec
  import arb_pkg::*;
(
  input  logic             gnt_valid,
  input  logic [1:0]       gnt_id,
  output logic [ARB_N-1:0] gnt
);

  // Decode the grant index while the grant is valid, all zero otherwise.
  always_comb begin
    gnt = 4'b0000;
    if (gnt_valid) begin
      case (gnt_id)
        2'd0:    gnt = 4'b0001;
        2'd1:    gnt = 4'b0010;
        2'd2:    gnt = 4'b0100;
        2'd3:    gnt = 4'b1000;
        default: gnt = 4'b0000;
      endcase
    end else begin
      gnt = 4'b0000;
    end
  end

endmodule

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter driving a decoded grant vector.
// Define ARB_TIMEOUT_EN to force rotation after HOLD_MAX cycles of contention.
module arb4_rr
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ARB_N-1:0] req,
  output logic [ARB_N-1:0] gnt,
  output logic             gnt_valid,
  output logic [1:0]       gnt_id
);

  arb_state_t       state_r, state_nxt_s;
  logic [1:0]       ptr_r, ptr_nxt_s;
  logic [1:0]       gnt_id_r, id_nxt_s;
  logic [ARB_N-1:0] others_s;
  logic             timeout_s;

  if (HOLD_MAX < 2) begin : g_hold_max_check
    $error("arb4_rr: HOLD_MAX must be 2 or greater");
  end

  // Requests pending from anyone other than the current owner.
  assign others_s = req & ~(4'b0001 << gnt_id_r);

`ifdef ARB_TIMEOUT_EN
  localparam int            CW       = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  logic [CW-1:0] hold_cnt_r, cnt_nxt_s;

  assign timeout_s = (hold_cnt_r == CNT_LAST) && (others_s != 4'b0000);

  // Hold counter: cleared on every new grant, saturates while unopposed.
  always_comb begin
    cnt_nxt_s = hold_cnt_r;
    if (state_nxt_s != state_r || id_nxt_s != gnt_id_r) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (state_r == GRANT && hold_cnt_r != CNT_LAST) begin
      cnt_nxt_s = hold_cnt_r + CW'(1);
    end else begin
      cnt_nxt_s = hold_cnt_r;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_r <= {CW{1'b0}};
    end else begin
      hold_cnt_r <= cnt_nxt_s;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State, pointer and grant-index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      ptr_r    <= 2'd0;
      gnt_id_r <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      ptr_r    <= ptr_nxt_s;
      gnt_id_r <= id_nxt_s;
    end
  end

  // Next-state logic: grant from IDLE, hold, or rotate on release/timeout.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    id_nxt_s    = gnt_id_r;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) begin
          id_nxt_s    = pick(ptr_r, req);
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (!req[gnt_id_r] || timeout_s) begin
          // Owner goes to the back of the scan; masking it out keeps a
          // preempted owner from winning its own rotation.
          ptr_nxt_s = gnt_id_r + 2'd1;
          if (others_s != 4'b0000) begin
            id_nxt_s    = pick(gnt_id_r + 2'd1, others_s);
            state_nxt_s = GRANT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers so the decoded grant is glitch-free.
  always_comb begin
    gnt_valid = (state_r == GRANT);
    gnt_id    = gnt_id_r;
  end

  grant_dec u_grant_dec (
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .gnt       (gnt)
  );

endmodule

// File: tb/tb_arb4_rr.sv
// Directed bench for arb4_rr with hand-computed grant sequences.
// Timeout scenarios follow the ARB_TIMEOUT_EN build define.
module tb_arb4_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;

  int checks   = 0;
  int failures = 0;

  arb4_rr #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: grant is one-hot-or-zero and matches the decode of valid/id.
  always @(negedge clk) begin
    logic [3:0] dec;
    dec = gnt_valid ? (4'b0001 << gnt_id) : 4'b0000;
    check_eq("onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
    check_eq("decode", {28'd0, gnt}, {28'd0, dec});
  end

  initial begin
    logic [3:0] exp;
    rst = 1'b1;
    req = 4'b0000;
    tick();
    check_eq("rst_gnt", {28'd0, gnt}, 32'h0);
    check_eq("rst_valid", {31'd0, gnt_valid}, 32'h0);
    check_eq("rst_id", {30'd0, gnt_id}, 32'h0);
    rst = 1'b0;
    tick();
    check_eq("idle_gnt", {28'd0, gnt}, 32'h0);

    // All requesting: each owner releases after two cycles.
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      check_eq("rr_first", {28'd0, gnt}, {28'd0, exp});
      tick();
      check_eq("rr_second", {28'd0, gnt}, {28'd0, exp});
      if (k < 4) begin
        req = 4'b1111 & ~exp;
        tick();
        req = 4'b1111;
      end
    end
    req = 4'b0000;
    tick();
    check_eq("rr_idle", {28'd0, gnt}, 32'h0);

    // Wrap-around: requester 3 served, pointer wraps to 0.
    req = 4'b1000;
    tick();
    check_eq("wrap_r3", {28'd0, gnt}, 32'h8);
    req = 4'b0000;
    tick();
    check_eq("wrap_idle", {28'd0, gnt}, 32'h0);
    req = 4'b1001;
    tick();
    check_eq("wrap_r0", {28'd0, gnt}, 32'h1);
    tick();
    check_eq("wrap_r0_hold", {28'd0, gnt}, 32'h1);
    req = 4'b1000;
    tick();
    check_eq("wrap_r3b", {28'd0, gnt}, 32'h8);
    req = 4'b0000;
    tick();
    check_eq("wrap_idle2", {28'd0, gnt}, 32'h0);

    // Single owner held for 20 cycles.
    req = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("single_hold", {28'd0, gnt}, 32'h2);
    end
    req = 4'b0000;
    tick();
    check_eq("single_drop", {28'd0, gnt}, 32'h0);
    check_eq("single_valid", {31'd0, gnt_valid}, 32'h0);

    // Contention on requester 0 with requester 2 arriving.
    req = 4'b0001;
    tick();
    check_eq("to_grant0", {28'd0, gnt}, 32'h1);
    req = 4'b0101;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("to_hold0", {28'd0, gnt}, 32'h1);
    end
    tick();
    check_eq("to_rotate2", {28'd0, gnt}, 32'h4);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("to_hold2", {28'd0, gnt}, 32'h4);
    end
    tick();
    check_eq("to_back0", {28'd0, gnt}, 32'h1);
`else
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("nto_hold0", {28'd0, gnt}, 32'h1);
    end
    req = 4'b0100;
    tick();
    check_eq("nto_rel2", {28'd0, gnt}, 32'h4);
`endif
    req = 4'b0000;
    tick();
    check_eq("to_idle", {28'd0, gnt}, 32'h0);

    // Lone owner keeps the grant in either build.
    req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("lone_hold", {28'd0, gnt}, 32'h1);
    end

    // Simultaneous release and new request: direct handover.
    req = 4'b0010;
    tick();
    check_eq("swap_r1", {28'd0, gnt}, 32'h2);

    // Asynchronous reset while requester 2 owns.
    req = 4'b0100;
    tick();
    check_eq("pre_rst", {28'd0, gnt}, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_gnt", {28'd0, gnt}, 32'h0);
    check_eq("async_valid", {31'd0, gnt_valid}, 32'h0);
    req = 4'b0000;
    tick();
    rst = 1'b0;
    req = 4'b0001;
    tick();
    check_eq("post_rst", {28'd0, gnt}, 32'h1);
    req = 4'b0000;
    tick();

    // Pointer restarts at 0 after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1110;
    tick();
    check_eq("ptr_restart", {28'd0, gnt}, 32'h2);
    req = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
